// File: rtl/hamming_encode_stream.sv
// Streaming Hamming encoder with a 2-entry output buffer and codeword counter.
//
// Codeword positions are numbered 1..DATA_W+PAR_W. Position k sits at Out_Data[k-1].
// Power-of-two positions 2^j hold parity bit p(j+1). All other positions hold the
// data bits in ascending order.
//
// Optional feature: define HAMMING_SECDED_EN to append an overall even-parity bit
// at Out_Data[CODE_W-1]. This gives a SECDED code.
//
// Ports:
//   Clk, Reset_b          clock; synchronous active-low reset
//   In_Data/Valid/Ready   upstream word handshake
//   Out_Data/Valid/Ready  downstream codeword handshake (head of buffer)
//   Cnt_Clr               synchronous clear of Word_Count (wins over increment)
//   Word_Count            wrapping count of output handshakes
module hamming_encode_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WCNT_W = 16,
  // Smallest P with 2^P >= DATA_W+P+1, for DATA_W in 1..57.
  localparam int unsigned PAR_W = (DATA_W <= 1)  ? 2 :
                                  (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 :
                                  (DATA_W <= 57) ? 6 : 7,
`ifdef HAMMING_SECDED_EN
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1
`else
  localparam int unsigned CODE_W = DATA_W + PAR_W
`endif
) (
  input  logic              Clk,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [CODE_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  input  logic              Cnt_Clr,
  output logic [WCNT_W-1:0] Word_Count
);

  localparam int unsigned HAM_W = DATA_W + PAR_W;

  // Data positions whose index has bit j set; these feed parity p(j+1).
  function automatic logic [HAM_W-1:0] par_mask(input int unsigned j);
    logic [HAM_W-1:0] m;
    m = '0;
    for (int unsigned k = 1; k <= HAM_W; k++) begin
      if ((((k >> j) & 1) != 0) && ((k & (k - 1)) != 0)) begin
        m = m | ({{(HAM_W - 1){1'b0}}, 1'b1} << (k - 1));
      end
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic [HAM_W-1:0]  ham_d;  // data bits placed, parity slots zero
  logic [HAM_W-1:0]  ham;
  logic [CODE_W-1:0] code;

  for (genvar k = 1; k <= HAM_W; k++) begin : g_pos
    if ((k & (k - 1)) != 0) begin : g_data
      // Data index = position minus the parity slots at or below it.
      assign ham_d[k-1] = In_Data[k - 1 - $clog2(k + 1)];
      assign ham[k-1]   = ham_d[k-1];
    end else begin : g_par
      localparam logic [HAM_W-1:0] Mask = par_mask($clog2(k));
      assign ham_d[k-1] = 1'b0;
      assign ham[k-1]   = ^(ham_d & Mask);
    end
  end

`ifdef HAMMING_SECDED_EN
  assign code = {^ham, ham};
`else
  assign code = ham;
`endif

  // ---------------------------------------------------------------------------
  // Two-entry buffer and counter
  // ---------------------------------------------------------------------------
  logic [CODE_W-1:0] head_q, head_d;
  logic [CODE_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rdy_q;  // low until the first edge out of reset
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              push, pop;

  // Registers only (plus reset level): no path from Out_Ready.
  assign In_Ready   = Reset_b && rdy_q && (cnt_q != 2'd2);
  assign Out_Valid  = (cnt_q != 2'd0);
  assign Out_Data   = head_q;
  assign Word_Count = wcnt_q;

  assign push = In_Valid && In_Ready;
  assign pop  = Out_Valid && Out_Ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_d - 2'd1;
    end
    // Evaluated after the pop so a push into a just-emptied slot lands at head.
    if (push) begin
      if (cnt_d == 2'd0) begin
        head_d = code;
      end else begin
        tail_d = code;
      end
      cnt_d = cnt_d + 2'd1;
    end
    if (Cnt_Clr) begin
      wcnt_d = '0;
    end else if (pop) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_b) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      wcnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= 1'b1;
      wcnt_q <= wcnt_d;
    end
  end

endmodule
